// File: rtl/serial_pattern_transmitter.sv
// Serial pattern transmitter: sends PATTERN MSB-first on 'a', N times, with GAP_CYCLES idle cycles in between.
// Optional feature macro: SERIAL_PATTERN_TX_PARITY_EN appends an even-parity bit to every frame.
module serial_pattern_transmitter #(
   parameter int unsigned          PATTERN_W  = 6,
   parameter logic [PATTERN_W-1:0] PATTERN    = 6'b110011,
   parameter int unsigned          GAP_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_valid,
   output logic       start_ready,
   input  logic [7:0] repeat_cnt,
   input  logic       abort,
   output logic       a,
   output logic       a_valid,
   output logic       busy,
   output logic       done
);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
   localparam int unsigned FRAME_W = PATTERN_W + 1;
`else
   localparam int unsigned FRAME_W = PATTERN_W;
`endif
   localparam int unsigned BW = $clog2(PATTERN_W + 1);
   localparam logic [BW-1:0] LAST_IDX = BW'(FRAME_W - 1);
   localparam logic [7:0]    GAP_LAST = 8'(GAP_CYCLES - 1);

   // Frame bits in transmit order, indexed directly by bit_idx.
   function automatic logic [2**BW-1:0] frame_bits();
      logic [2**BW-1:0] f;
      f = '0;
      for (int i = 0; i < PATTERN_W; i++) f[i] = PATTERN[PATTERN_W-1-i];
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      f[PATTERN_W] = ^PATTERN;
`endif
      return f;
   endfunction

   localparam logic [2**BW-1:0] FRAME_BITS = frame_bits();

   typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

   state_t        state, state_nxt;
   logic [BW-1:0] bit_idx, bit_idx_nxt;
   logic [7:0]    rep_left, rep_left_nxt;
   logic [7:0]    gap_cnt, gap_cnt_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         bit_idx  <= '0;
         rep_left <= '0;
         gap_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         bit_idx  <= bit_idx_nxt;
         rep_left <= rep_left_nxt;
         gap_cnt  <= gap_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      bit_idx_nxt  = bit_idx;
      rep_left_nxt = rep_left;
      gap_cnt_nxt  = gap_cnt;
      unique case (state)
         IDLE: begin
            if (start_valid && !abort) begin
               rep_left_nxt = repeat_cnt;
               bit_idx_nxt  = '0;
               gap_cnt_nxt  = '0;
               state_nxt    = (repeat_cnt == 8'd0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_nxt    = IDLE;
               bit_idx_nxt  = '0;
               rep_left_nxt = '0;
            end else if (bit_idx == LAST_IDX) begin
               // End of frame: rep_left counts down to exactly zero, never wraps.
               bit_idx_nxt  = '0;
               rep_left_nxt = rep_left - 8'd1;
               if (rep_left == 8'd1) begin
                  state_nxt = DONE;
               end else if (GAP_CYCLES > 0) begin
                  state_nxt   = GAP;
                  gap_cnt_nxt = '0;
               end
            end else begin
               bit_idx_nxt = bit_idx + BW'(1);
            end
         end
         GAP: begin
            if (abort) begin
               state_nxt    = IDLE;
               gap_cnt_nxt  = '0;
               rep_left_nxt = '0;
            end else if (gap_cnt == GAP_LAST) begin
               state_nxt   = SHIFT;
               gap_cnt_nxt = '0;
               bit_idx_nxt = '0;
            end else begin
               gap_cnt_nxt = gap_cnt + 8'd1;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      start_ready = (state == IDLE);
      a_valid     = (state == SHIFT);
      a           = (state == SHIFT) ? FRAME_BITS[bit_idx] : 1'b0;
      busy        = (state != IDLE);
      done        = (state == DONE);
   end

endmodule

// File: tb/tb_serial_pattern_transmitter.sv
// Bench for serial_pattern_transmitter: per-cycle scoreboard of {busy, a_valid, a, done, start_ready}.
module tb_serial_pattern_transmitter;
   localparam int PW = 6;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
   localparam int FW = PW + 1;
`else
   localparam int FW = PW;
`endif
   localparam logic [5:0] PAT  = 6'b110011;
   localparam logic [5:0] PAT2 = 6'b110010;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, abort;
   logic [7:0] repeat_cnt;
   logic       sv0, sv1, sv2;
   logic       rdy0, a0, av0, busy0, done0;
   logic       rdy1, a1, av1, busy1, done1;
   logic       rdy2, a2, av2, busy2, done2;

   serial_pattern_transmitter #(.PATTERN_W(6), .PATTERN(PAT), .GAP_CYCLES(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .start_valid(sv0), .start_ready(rdy0), .repeat_cnt(repeat_cnt),
      .abort(abort), .a(a0), .a_valid(av0), .busy(busy0), .done(done0));
   serial_pattern_transmitter #(.PATTERN_W(6), .PATTERN(PAT), .GAP_CYCLES(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(rdy1), .repeat_cnt(repeat_cnt),
      .abort(abort), .a(a1), .a_valid(av1), .busy(busy1), .done(done1));
   serial_pattern_transmitter #(.PATTERN_W(6), .PATTERN(PAT2), .GAP_CYCLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start_valid(sv2), .start_ready(rdy2), .repeat_cnt(repeat_cnt),
      .abort(abort), .a(a2), .a_valid(av2), .busy(busy2), .done(done2));

   int         sel;
   logic [4:0] obs;
   always_comb begin
      case (sel)
         1:       obs = {busy1, av1, a1, done1, rdy1};
         2:       obs = {busy2, av2, a2, done2, rdy2};
         default: obs = {busy0, av0, a0, done0, rdy0};
      endcase
   end

   logic [4:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   // Expected cycles after acceptance: n frames, gaps between, done cycle, then idle.
   task automatic push_tx(input int n, input int gap, input logic [5:0] pat);
      logic [5:0] p;
      for (int r = 0; r < n; r++) begin
         p = pat;
         for (int i = 0; i < PW; i++) begin
            exp_q.push_back({2'b11, p[5], 2'b00});
            p = p << 1;
         end
         if (FW > PW) exp_q.push_back({2'b11, ^pat, 2'b00});
         if (r < n - 1)
            for (int g = 0; g < gap; g++) exp_q.push_back(5'b10000);
      end
      exp_q.push_back(5'b10010);
      exp_q.push_back(5'b00001);
   endtask

   task automatic launch(input int which, input logic [7:0] n);
      @(negedge clk);
      repeat_cnt = n;
      case (which)
         1:       sv1 = 1'b1;
         2:       sv2 = 1'b1;
         default: sv0 = 1'b1;
      endcase
      @(posedge clk);
      #1;
      sv0 = 1'b0; sv1 = 1'b0; sv2 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; abort = 1'b0; repeat_cnt = 8'd0;
      sv0 = 1'b0; sv1 = 1'b0; sv2 = 1'b0; sel = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         n_checks++;
         if (obs[4:1] !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs dut%0d: got %b want 0000 (busy/vld/a/done)", s, obs[4:1]);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         n_checks++;
         if (obs !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_release dut%0d: got %b want 00001", s, obs);
         end
      end
      sel = 0;
   endtask

   task automatic test_basic();
      logic [4:0] e;
      int idx;
      sel = 0;
      launch(0, 8'd1);
      push_tx(1, 2, PAT);
      idx = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         @(negedge clk);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL basic cyc%0d: got %b want %b (busy/vld/a/done/rdy)", idx + 1, obs, e);
         end
         sv0 = (idx == 2);  // request while busy must be ignored
         idx++;
      end
      sv0 = 1'b0;
   endtask

   task automatic test_repeat(input int which, input int gap);
      logic [4:0] e;
      int idx, done_cyc;
      sel = which;
      launch(which, 8'd3);
      push_tx(3, gap, PAT);
      idx = 0; done_cyc = -1;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         @(negedge clk);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL repeat3_gap%0d cyc%0d: got %b want %b", gap, idx + 1, obs, e);
         end
         if (obs[1] && done_cyc < 0) done_cyc = idx + 1;
         idx++;
      end
      n_checks++;
      if (done_cyc !== 3 * FW + 2 * gap + 1) begin
         n_fail++;
         $display("FAIL repeat3_done_cycle gap%0d: got %0d want %0d", gap, done_cyc, 3 * FW + 2 * gap + 1);
      end
   endtask

   task automatic test_loopback();
      logic [4:0] e;
      logic [5:0] win;
      int nbits, hits;
      sel = 1;
      launch(1, 8'd2);
      push_tx(2, 0, PAT);
      win = '0; nbits = 0; hits = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         @(negedge clk);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL loopback stream: got %b want %b", obs, e);
         end
         if (obs[3]) begin
            win = {win[4:0], obs[2]};
            nbits++;
            if (nbits >= 6 && win == PAT) hits++;
         end
      end
      n_checks++;
      if (hits !== 2) begin
         n_fail++;
         $display("FAIL loopback_detect_count: got %0d want 2", hits);
      end
   endtask

   task automatic test_zero();
      logic [4:0] e;
      sel = 0;
      launch(0, 8'd0);
      abort = 1'b1;  // abort while in DONE must not suppress done
      exp_q.push_back(5'b10010);
      exp_q.push_back(5'b00001);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         @(negedge clk);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL zero_repeat: got %b want %b", obs, e);
         end
         abort = 1'b0;
      end
   endtask

   task automatic test_abort();
      logic [4:0] e;
      logic [5:0] p;
      int idx;
      sel = 0;
      launch(0, 8'd2);
      p = PAT;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back({2'b11, p[5], 2'b00});
         p = p << 1;
      end
      exp_q.push_back(5'b00001);
      idx = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         @(negedge clk);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL abort cyc%0d: got %b want %b", idx + 1, obs, e);
         end
         if (idx == 2) abort = 1'b1;
         idx++;
      end
      abort = 1'b0; sv0 = 1'b1; repeat_cnt = 8'd1;
      @(posedge clk);
      #1 sv0 = 1'b0;
      push_tx(1, 2, PAT);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         @(negedge clk);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL after_abort: got %b want %b", obs, e);
         end
      end
      @(negedge clk);
      abort = 1'b1; sv0 = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0; sv0 = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== 5'b00001) begin
            n_fail++;
            $display("FAIL abort_wins_idle: got %b want 00001", obs);
         end
      end
   endtask

   task automatic test_max();
      logic [4:0] e;
      int idx;
      sel = 1;
      launch(1, 8'd255);
      push_tx(255, 0, PAT);
      idx = 0;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         @(negedge clk);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL repeat255 cyc%0d: got %b want %b", idx + 1, obs, e);
         end
         idx++;
      end
   endtask

   task automatic test_pattern2();
      logic [4:0] e;
      sel = 2;
      launch(2, 8'd2);
      push_tx(2, 2, PAT2);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         @(negedge clk);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL pattern2: got %b want %b", obs, e);
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [4:0] e;
      logic [5:0] p;
      sel = 0;
      launch(0, 8'd2);
      p = PAT;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back({2'b11, p[5], 2'b00});
         p = p << 1;
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         @(negedge clk);
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL midframe_pre: got %b want %b", obs, e);
         end
      end
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (obs[4:1] !== 4'b0000) begin
         n_fail++;
         $display("FAIL midframe_reset: got %b want 0000 (busy/vld/a/done)", obs[4:1]);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== 5'b00001) begin
            n_fail++;
            $display("FAIL midframe_after: got %b want 00001", obs);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_repeat(0, 2);
      test_repeat(1, 0);
      test_loopback();
      test_zero();
      test_abort();
      test_max();
      test_pattern2();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
